// File: rtl/edge_event_arbiter.sv
// Edge event arbiter for the ACF sampling front end.
// Generates the shared sample-enable strobe from a programmable divider and
// counts those strobes as a timestamp. It latches rise/fall pulses from every
// edge detector into per-slot pending registers, and serves them round-robin
// onto one valid/ready event stream.
// Slot numbering: slot 2*ch is the rising edge of channel ch and slot 2*ch+1
// is its falling edge, so a rise is served before a fall of the same channel.

module edge_event_arbiter #(
   parameter int NCH   = 4,
   parameter int DIV_W = 16,
   parameter int TS_W  = 32,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             smpl_clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             ce,
   input  logic [NCH-1:0]   rise,
   input  logic [NCH-1:0]   fall,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [CH_W-1:0]  ev_chan,
   output logic             ev_pol,
   output logic [TS_W-1:0]  ev_ts,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int NS   = 2 * NCH;
   localparam int SL_W = $clog2(NS);

   logic [DIV_W-1:0] div_cnt;
   logic             ce_d;
   logic [TS_W-1:0]  ts;
   logic [NS-1:0]    pending;
   logic [TS_W-1:0]  slot_ts [NS];
   logic [NS-1:0]    capture;
   logic [NS-1:0]    grant;
   logic [SL_W-1:0]  rr;
   logic [SL_W-1:0]  win;
   logic [SL_W:0]    scan_idx;
   logic             found;
   logic             load;
   logic             ovf_hit;

   // The compare is ">=" so that lowering div mid-count ends the period at
   // once instead of letting the counter run all the way round.
   assign ce = resetn & enable & (div_cnt >= div);

   // The output register may take a new event whenever it is empty or its
   // current event is being accepted this cycle.
   assign load = ~ev_valid | ev_ready;

   // Sample divider: counts while enabled and restarts on every strobe.
   always_ff @(posedge smpl_clk or negedge resetn) begin
      if (!resetn)
         div_cnt <= '0;
      else if (!enable || (div_cnt >= div))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // Timestamp counts strobes, and ce_d marks the cycle when detector outputs are valid.
   always_ff @(posedge smpl_clk or negedge resetn) begin
      if (!resetn) begin
         ce_d <= 1'b0;
         ts   <= '0;
      end else begin
         ce_d <= ce;
         if (ce)
            ts <= ts + TS_W'(1);
      end
   end

   // Map detector pulses onto slots, but only in the cycle after a strobe.
   always_comb begin
      capture = '0;
      if (ce_d && enable) begin
         for (int c = 0; c < NCH; c++) begin
            capture[2*c]   = rise[c];
            capture[2*c+1] = fall[c];
         end
      end
   end

   // Round-robin search: first pending slot at or after rr, wrapping around.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int k = 0; k < NS; k++) begin
         scan_idx = {1'b0, rr} + (SL_W+1)'(k);
         if (scan_idx >= (SL_W+1)'(NS))
            scan_idx = scan_idx - (SL_W+1)'(NS);
         if (!found && pending[scan_idx[SL_W-1:0]]) begin
            found = 1'b1;
            win   = scan_idx[SL_W-1:0];
         end
      end
   end

   // One-hot grant of the winner, valid only when the output register loads.
   always_comb begin
      grant = '0;
      if (load && found)
         grant[win] = 1'b1;
   end

   // A capture into a slot that is still occupied and not leaving this cycle is lost.
   assign ovf_hit = |(capture & pending & ~grant);

   // Pending slots: a capture refills a slot that is free or being granted, and a grant empties it.
   always_ff @(posedge smpl_clk or negedge resetn) begin
      if (!resetn) begin
         pending <= '0;
         for (int s = 0; s < NS; s++)
            slot_ts[s] <= '0;
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (capture[s] && !(pending[s] && !grant[s])) begin
               pending[s] <= 1'b1;
               slot_ts[s] <= ts;
            end else if (grant[s]) begin
               pending[s] <= 1'b0;
            end
         end
      end
   end

   // Output register and round-robin pointer: payload changes only when the register loads.
   always_ff @(posedge smpl_clk or negedge resetn) begin
      if (!resetn) begin
         ev_valid <= 1'b0;
         ev_chan  <= '0;
         ev_pol   <= 1'b0;
         ev_ts    <= '0;
         rr       <= '0;
      end else if (load) begin
         if (found) begin
            ev_valid <= 1'b1;
            ev_chan  <= CH_W'(win >> 1);
            ev_pol   <= ~win[0];
            ev_ts    <= slot_ts[win];
            rr       <= (win == SL_W'(NS - 1)) ? '0 : win + SL_W'(1);
         end else begin
            ev_valid <= 1'b0;
         end
      end
   end

   // Sticky overflow flag: a new loss wins over a simultaneous clear.
   always_ff @(posedge smpl_clk or negedge resetn) begin
      if (!resetn)
         overflow <= 1'b0;
      else if (ovf_hit)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Testbench for edge_event_arbiter with NCH=4.
// The stimulus process drives directed cycle-by-cycle vectors and queues the
// events it expects. A forked monitor checks every presented event against
// the head of that queue, and pops the entry once the event is accepted.

module tb_edge_event_arbiter;

   logic        smpl_clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic [15:0] div;
   logic        ce;
   logic [3:0]  rise;
   logic [3:0]  fall;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_chan;
   logic        ev_pol;
   logic [31:0] ev_ts;
   logic        overflow;
   logic        ovf_clr;

   typedef struct packed {
      logic [1:0]  chan;
      logic        pol;
      logic [31:0] ts;
   } evT;

   evT          expQ[$];
   int          errors = 0;
   int          checks = 0;
   logic [2:0]  slotIdx;

   edge_event_arbiter #(.NCH(4), .DIV_W(16), .TS_W(32)) dut (
      .smpl_clk (smpl_clk),
      .resetn   (resetn),
      .enable   (enable),
      .div      (div),
      .ce       (ce),
      .rise     (rise),
      .fall     (fall),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_chan  (ev_chan),
      .ev_pol   (ev_pol),
      .ev_ts    (ev_ts),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   // Free-running sample clock with a 10-unit period.
   always #5 smpl_clk = ~smpl_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] d, input logic [3:0] r,
                                input logic [3:0] f, input logic rdy, input logic clr);
      enable   = en;
      div      = d;
      rise     = r;
      fall     = f;
      ev_ready = rdy;
      ovf_clr  = clr;
   endtask

   task automatic pushExp(input logic [1:0] c, input logic p, input logic [31:0] t);
      evT e;
      e.chan = c;
      e.pol  = p;
      e.ts   = t;
      expQ.push_back(e);
   endtask

   task automatic nextCycle;
      @(posedge smpl_clk);
      #1;
   endtask

   task automatic doReset;
      resetn = 1'b0;
      applyStimulus(1'b0, 16'd0, 4'b0, 4'b0, 1'b0, 1'b0);
      repeat (2) @(posedge smpl_clk);
      #1;
      expQ.delete();
      resetn = 1'b1;
   endtask

   // Scoreboard monitor: compare each presented event, and pop it once it is accepted.
   task automatic monitorLoop;
      forever begin
         @(negedge smpl_clk);
         if (resetn && ev_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_event", 64'(ev_valid), 64'(0));
            end else begin
               checkOutput("ev_chan", 64'(ev_chan), 64'(expQ[0].chan));
               checkOutput("ev_pol", 64'(ev_pol), 64'(expQ[0].pol));
               checkOutput("ev_ts", 64'(ev_ts), 64'(expQ[0].ts));
               if (ev_ready)
                  void'(expQ.pop_front());
            end
         end
      end
   endtask

   initial begin
      fork
         monitorLoop();
      join_none

      // Reset state: ce must stay low even with enable=1 and div=0.
      resetn = 1'b0;
      applyStimulus(1'b1, 16'd0, 4'b0, 4'b0, 1'b0, 1'b0);
      #2;
      checkOutput("rst_ce", 64'(ce), 64'(0));
      checkOutput("rst_ev_valid", 64'(ev_valid), 64'(0));
      checkOutput("rst_ev_chan", 64'(ev_chan), 64'(0));
      checkOutput("rst_ev_pol", 64'(ev_pol), 64'(0));
      checkOutput("rst_ev_ts", 64'(ev_ts), 64'(0));
      checkOutput("rst_overflow", 64'(overflow), 64'(0));

      // Divider at div=3: strobe on every 4th cycle, with timestamps 1, 2, 3; then div=0 holds ce high.
      $display("[TB] phase: divider and timestamp");
      doReset();
      for (int c = 1; c <= 22; c++) begin
         applyStimulus(1'b1, (c >= 17) ? 16'd0 : 16'd3,
                       (c == 5) ? 4'b0001 : (c == 9) ? 4'b0010 : (c == 13) ? 4'b0100 : 4'b0000,
                       4'b0, 1'b1, 1'b0);
         if (c == 5)  pushExp(2'd0, 1'b1, 32'd1);
         if (c == 9)  pushExp(2'd1, 1'b1, 32'd2);
         if (c == 13) pushExp(2'd2, 1'b1, 32'd3);
         @(negedge smpl_clk);
         if (c <= 16)
            checkOutput("ce_div3", 64'(ce), 64'((c % 4) == 0));
         else if (c <= 20)
            checkOutput("ce_div0", 64'(ce), 64'(1));
         nextCycle();
      end
      checkOutput("queue_drained_a", 64'(expQ.size()), 64'(0));

      // Single rise on channel 2 at ts=5: valid for exactly one cycle, two cycles after the pulse.
      $display("[TB] phase: single event latency");
      doReset();
      for (int c = 1; c <= 10; c++) begin
         applyStimulus(1'b1, 16'd0, (c == 6) ? 4'b0100 : 4'b0000, 4'b0, 1'b1, 1'b0);
         if (c == 6) pushExp(2'd2, 1'b1, 32'd5);
         @(negedge smpl_clk);
         if (c >= 6)
            checkOutput("single_valid", 64'(ev_valid), 64'(c == 8));
         nextCycle();
      end
      checkOutput("queue_drained_b", 64'(expQ.size()), 64'(0));

      // All 8 slots fire on one strobe: back-to-back events in slot order, all with ts=1.
      $display("[TB] phase: full burst");
      doReset();
      for (int c = 1; c <= 16; c++) begin
         applyStimulus(1'b1, 16'd3, (c == 5) ? 4'hF : 4'h0, (c == 5) ? 4'hF : 4'h0, 1'b1, 1'b0);
         if (c == 5) begin
            for (int s = 0; s < 8; s++) begin
               slotIdx = 3'(s);
               pushExp(slotIdx[2:1], ~slotIdx[0], 32'd1);
            end
         end
         @(negedge smpl_clk);
         if (c >= 5)
            checkOutput("burst_valid", 64'(ev_valid), 64'((c >= 7) && (c <= 14)));
         nextCycle();
      end
      checkOutput("queue_drained_c", 64'(expQ.size()), 64'(0));

      // Stalled consumer on ch1 rise: the third pulse is dropped, and the older ts values survive.
      $display("[TB] phase: overflow");
      doReset();
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1'b1, 16'd3, (c == 5 || c == 9 || c == 13) ? 4'b0010 : 4'b0000,
                       4'b0, (c >= 15), (c == 18));
         if (c == 5) pushExp(2'd1, 1'b1, 32'd1);
         if (c == 9) pushExp(2'd1, 1'b1, 32'd2);
         @(negedge smpl_clk);
         if (c == 13 || c == 14 || c == 18 || c == 19)
            checkOutput("overflow_flag", 64'(overflow), 64'(c == 14 || c == 18));
         if (c == 17)
            checkOutput("ovf_idle_after_drain", 64'(ev_valid), 64'(0));
         nextCycle();
      end
      checkOutput("queue_drained_d", 64'(expQ.size()), 64'(0));

      // Continuous ch0/ch3 rises at div=0: grants alternate, and payload holds while ready is low.
      $display("[TB] phase: round robin");
      doReset();
      pushExp(2'd0, 1'b1, 32'd1);
      pushExp(2'd3, 1'b1, 32'd1);
      pushExp(2'd0, 1'b1, 32'd2);
      pushExp(2'd3, 1'b1, 32'd3);
      pushExp(2'd0, 1'b1, 32'd4);
      pushExp(2'd3, 1'b1, 32'd5);
      pushExp(2'd0, 1'b1, 32'd6);
      pushExp(2'd3, 1'b1, 32'd7);
      pushExp(2'd0, 1'b1, 32'd8);
      for (int c = 1; c <= 16; c++) begin
         applyStimulus(1'b1, 16'd0, (c <= 9) ? 4'b1001 : 4'b0000, 4'b0,
                       !(c == 10 || c == 12), 1'b0);
         @(negedge smpl_clk);
         if (c == 15) begin
            checkOutput("rr_idle", 64'(ev_valid), 64'(0));
            checkOutput("rr_overflow", 64'(overflow), 64'(1));
         end
         nextCycle();
      end
      checkOutput("queue_drained_e", 64'(expQ.size()), 64'(0));

      // Reset while an event is presented and slots are pending: everything is discarded at once.
      $display("[TB] phase: reset mid-operation");
      doReset();
      pushExp(2'd0, 1'b1, 32'd1);
      for (int c = 1; c <= 5; c++) begin
         applyStimulus(1'b1, 16'd0, (c == 2 || c == 3) ? 4'hF : 4'h0, 4'b0, 1'b0, 1'b0);
         @(negedge smpl_clk);
         if (c == 5) begin
            checkOutput("pre_reset_valid", 64'(ev_valid), 64'(1));
            checkOutput("pre_reset_overflow", 64'(overflow), 64'(1));
         end
         nextCycle();
      end
      resetn = 1'b0;
      #1;
      checkOutput("midrst_ev_valid", 64'(ev_valid), 64'(0));
      checkOutput("midrst_overflow", 64'(overflow), 64'(0));
      checkOutput("midrst_ce", 64'(ce), 64'(0));
      checkOutput("midrst_ev_ts", 64'(ev_ts), 64'(0));
      expQ.delete();
      applyStimulus(1'b0, 16'd0, 4'b0, 4'b0, 1'b1, 1'b0);
      repeat (2) @(posedge smpl_clk);
      #1;
      resetn = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge smpl_clk);
         checkOutput("no_stale_event", 64'(ev_valid), 64'(0));
         nextCycle();
      end
      for (int c = 1; c <= 6; c++) begin
         applyStimulus(1'b1, 16'd0, (c == 2) ? 4'b0010 : 4'b0000, 4'b0, 1'b1, 1'b0);
         if (c == 2) pushExp(2'd1, 1'b1, 32'd1);
         @(negedge smpl_clk);
         checkOutput("post_reset_valid", 64'(ev_valid), 64'(c == 4));
         nextCycle();
      end
      checkOutput("queue_drained_f", 64'(expQ.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
